// File: rtl/up_lb2axil.sv
// up_lb2axil: local-bus to AXI4-Lite master bridge.
// Turns single-cycle lb write/read request pulses into one AXI4-Lite
// transaction at a time and answers with a one-cycle wack/rack, carrying
// read data and an error flag for a non-OKAY response or a timeout.
// Every output comes straight from a flop.
`timescale 1ns/1ps
module up_lb2axil #(
  parameter int LB_DATA_WDTH = 32,
  parameter int LB_ADDR_WDTH = 32,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    up_clk,
  input  logic                    up_rstn,
  // local bus
  input  logic                    lb_wreq,
  input  logic [LB_ADDR_WDTH-1:0] lb_waddr,
  input  logic [LB_DATA_WDTH-1:0] lb_wdata,
  output logic                    lb_wack,
  input  logic                    lb_rreq,
  input  logic [LB_ADDR_WDTH-1:0] lb_raddr,
  output logic [LB_DATA_WDTH-1:0] lb_rdata,
  output logic                    lb_rack,
  output logic                    lb_err,
  // AXI4-Lite write address
  output logic                    up_axi_awvalid,
  output logic [LB_ADDR_WDTH-1:0] up_axi_awaddr,
  input  logic                    up_axi_awready,
  // AXI4-Lite write data
  output logic                    up_axi_wvalid,
  output logic [LB_DATA_WDTH-1:0] up_axi_wdata,
  output logic [3:0]              up_axi_wstrb,
  input  logic                    up_axi_wready,
  // AXI4-Lite write response
  input  logic                    up_axi_bvalid,
  input  logic [1:0]              up_axi_bresp,
  output logic                    up_axi_bready,
  // AXI4-Lite read address
  output logic                    up_axi_arvalid,
  output logic [LB_ADDR_WDTH-1:0] up_axi_araddr,
  input  logic                    up_axi_arready,
  // AXI4-Lite read data
  input  logic                    up_axi_rvalid,
  input  logic [1:0]              up_axi_rresp,
  input  logic [LB_DATA_WDTH-1:0] up_axi_rdata,
  output logic                    up_axi_rready
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_AW_W = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_RD_AR   = 3'd3;
  localparam logic [2:0] ST_RD_R    = 3'd4;

  logic [2:0]              state_q,     state_d;
  logic [TMR_W-1:0]        timer_q,     timer_d;
  logic                    awvalid_q,   awvalid_d;
  logic [LB_ADDR_WDTH-1:0] awaddr_q,    awaddr_d;
  logic                    wvalid_q,    wvalid_d;
  logic [LB_DATA_WDTH-1:0] wdata_q,     wdata_d;
  logic [3:0]              wstrb_q,     wstrb_d;
  logic                    bready_q,    bready_d;
  logic                    arvalid_q,   arvalid_d;
  logic [LB_ADDR_WDTH-1:0] araddr_q,    araddr_d;
  logic                    rready_q,    rready_d;
  logic                    lb_wack_q,   lb_wack_d;
  logic                    lb_rack_q,   lb_rack_d;
  logic                    lb_err_q,    lb_err_d;
  logic [LB_DATA_WDTH-1:0] lb_rdata_q,  lb_rdata_d;
  logic                    pend_q,      pend_d;
  logic [LB_ADDR_WDTH-1:0] pend_addr_q, pend_addr_d;

  logic tmo;
  logic aw_left;
  logic w_left;

  // Next-state logic for the FSM, the AXI channels and the lb responses.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path through this block can leave one unassigned and infer a latch.
    state_d     = state_q;
    timer_d     = (state_q == ST_IDLE) ? '0 : timer_q + TMR_W'(1);
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    lb_wack_d   = 1'b0;
    lb_rack_d   = 1'b0;
    lb_err_d    = 1'b0;
    lb_rdata_d  = lb_rdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;

    // >= rather than == keeps the abort reachable in every phase.
    tmo     = (state_q != ST_IDLE) && (timer_q >= TMR_LAST);
    aw_left = awvalid_q & ~up_axi_awready;
    w_left  = wvalid_q & ~up_axi_wready;

    case (state_q)
      ST_IDLE: begin
        if (lb_wreq) begin
          awaddr_d  = lb_waddr;
          wdata_d   = lb_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wstrb_d   = 4'hF;
          state_d   = ST_WR_AW_W;
          // A read arriving together with the write runs right after it.
          if (lb_rreq) begin
            pend_d      = 1'b1;
            pend_addr_d = lb_raddr;
          end
        end else if (pend_q) begin
          araddr_d  = pend_addr_q;
          pend_d    = 1'b0;
          arvalid_d = 1'b1;
          state_d   = ST_RD_AR;
        end else if (lb_rreq) begin
          araddr_d  = lb_raddr;
          arvalid_d = 1'b1;
          state_d   = ST_RD_AR;
        end
      end

      ST_WR_AW_W: begin
        if (!aw_left && !w_left) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wstrb_d   = 4'h0;
          bready_d  = 1'b1;
          state_d   = ST_WR_B;
        end else if (tmo) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wstrb_d   = 4'h0;
          lb_wack_d = 1'b1;
          lb_err_d  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          // AW and W complete independently of each other.
          awvalid_d = aw_left;
          wvalid_d  = w_left;
          wstrb_d   = w_left ? 4'hF : 4'h0;
        end
      end

      ST_WR_B: begin
        if (up_axi_bvalid && bready_q) begin
          bready_d  = 1'b0;
          lb_wack_d = 1'b1;
          lb_err_d  = (up_axi_bresp != 2'b00);
          state_d   = ST_IDLE;
        end else if (tmo) begin
          bready_d  = 1'b0;
          lb_wack_d = 1'b1;
          lb_err_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_AR: begin
        if (up_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end else if (tmo) begin
          arvalid_d  = 1'b0;
          lb_rack_d  = 1'b1;
          lb_err_d   = 1'b1;
          lb_rdata_d = '0;
          state_d    = ST_IDLE;
        end
      end

      ST_RD_R: begin
        if (up_axi_rvalid && rready_q) begin
          rready_d   = 1'b0;
          lb_rdata_d = up_axi_rdata;
          lb_rack_d  = 1'b1;
          lb_err_d   = (up_axi_rresp != 2'b00);
          state_d    = ST_IDLE;
        end else if (tmo) begin
          rready_d   = 1'b0;
          lb_rack_d  = 1'b1;
          lb_err_d   = 1'b1;
          lb_rdata_d = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wstrb_d   = 4'h0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight transaction without an ack.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      // NOTE: non-blocking assignments here let every flop sample the
      // previous cycle's values regardless of statement order.
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= 4'h0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      lb_wack_q   <= 1'b0;
      lb_rack_q   <= 1'b0;
      lb_err_q    <= 1'b0;
      lb_rdata_q  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      lb_wack_q   <= lb_wack_d;
      lb_rack_q   <= lb_rack_d;
      lb_err_q    <= lb_err_d;
      lb_rdata_q  <= lb_rdata_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign lb_wack        = lb_wack_q;
  assign lb_rack        = lb_rack_q;
  assign lb_err         = lb_err_q;
  assign lb_rdata       = lb_rdata_q;
  assign up_axi_awvalid = awvalid_q;
  assign up_axi_awaddr  = awaddr_q;
  assign up_axi_wvalid  = wvalid_q;
  assign up_axi_wdata   = wdata_q;
  assign up_axi_wstrb   = wstrb_q;
  assign up_axi_bready  = bready_q;
  assign up_axi_arvalid = arvalid_q;
  assign up_axi_araddr  = araddr_q;
  assign up_axi_rready  = rready_q;

endmodule
